// File: rtl/cpu_pkg.sv
// Shared CPU types: data word, opcode encoding, fetch FSM states and opcode helpers.
package cpu_pkg;

  localparam int unsigned WORD_W = 8;

  typedef logic [WORD_W-1:0] word;

  typedef enum logic [7:0] {
    NOP  = 8'h00,
    ADD  = 8'h01,
    SUB  = 8'h02,
    AND  = 8'h03,
    OR   = 8'h04,
    XOR  = 8'h05,
    WO   = 8'h06,
    HLT  = 8'h07,
    LDI  = 8'h10,
    ADDI = 8'h11,
    SUBI = 8'h12,
    ANDI = 8'h13,
    ORI  = 8'h14,
    JMP  = 8'h20,
    BEQ  = 8'h21,
    BNE  = 8'h22
  } e_instr;

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_ERR  = 2'd2
  } e_fetch_state;

  // Opcodes followed by an immediate byte; unknown encodings are treated as 1-byte.
  function automatic logic has_imm(input e_instr op);
    case (op)
      LDI, ADDI, SUBI, ANDI, ORI, JMP, BEQ, BNE: has_imm = 1'b1;
      default:                                   has_imm = 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] instr_len(input e_instr op);
    instr_len = 2'd1 + {1'b0, has_imm(op)};
  endfunction

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch: owns the PC, drives the 1-cycle ROM and hands instructions to the decoder.
// Optional PC overflow trap enabled by defining IFETCH_BOUND_EN.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int               WORD     = 8,
  parameter logic [WORD-1:0]  RESET_PC = {WORD{1'b0}}
) (
  input  logic            clk,
  input  logic            rst,
  output logic [WORD-1:0] mem_addr,
  input  e_instr          mem_instr,
  input  logic [WORD-1:0] mem_imm,
  output e_instr          dec_instr,
  output logic [WORD-1:0] dec_imm,
  output logic [WORD-1:0] dec_pc,
  output logic            dec_valid,
  input  logic            dec_ready,
  input  logic            redirect,
  input  logic [WORD-1:0] redirect_pc,
  output logic            fetch_err
);

  e_fetch_state    state_r;
  logic [WORD-1:0] pc_r;
  logic            dec_valid_r;
  logic            fetch_err_r;
  logic [WORD-1:0] next_pc_s;
  logic            carry_s;
  logic            advance_s;

  // Sequential successor of pc_r, sized by the opcode currently returned by the ROM.
  always_comb begin
`ifdef IFETCH_BOUND_EN
    {carry_s, next_pc_s} = {1'b0, pc_r} + {{WORD{1'b0}}, 1'b1}
                         + {{WORD{1'b0}}, has_imm(mem_instr)};
`else
    carry_s   = 1'b0;
    next_pc_s = pc_r + {{(WORD-1){1'b0}}, 1'b1} + {{(WORD-1){1'b0}}, has_imm(mem_instr)};
`endif
  end

  // A consumed sequential instruction only advances when it does not trip the bound.
  always_comb begin
    if (dec_ready && !carry_s) begin
      advance_s = 1'b1;
    end else begin
      advance_s = 1'b0;
    end
  end

  // ROM address: the PC that will be current next cycle, so data lines up with pc_r.
  always_comb begin
    mem_addr = pc_r;
    case (state_r)
      S_RUN: begin
        if (redirect) begin
          mem_addr = redirect_pc;
        end else if (advance_s) begin
          mem_addr = next_pc_s;
        end else begin
          mem_addr = pc_r;
        end
      end
      S_BOOT:  mem_addr = pc_r;
      S_ERR:   mem_addr = pc_r;
      default: mem_addr = pc_r;
    endcase
  end

  // Fetch FSM with registered valid/error flags; redirect outranks dec_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= S_BOOT;
      pc_r        <= RESET_PC;
      dec_valid_r <= 1'b0;
      fetch_err_r <= 1'b0;
    end else begin
      case (state_r)
        S_BOOT: begin
          state_r     <= S_RUN;
          dec_valid_r <= 1'b1;
        end
        S_RUN: begin
          if (redirect) begin
            pc_r <= redirect_pc;
          end else if (dec_ready) begin
            if (carry_s) begin
              state_r     <= S_ERR;
              dec_valid_r <= 1'b0;
              fetch_err_r <= 1'b1;
            end else begin
              pc_r <= next_pc_s;
            end
          end
        end
        S_ERR: begin
          state_r     <= S_ERR;
          dec_valid_r <= 1'b0;
          fetch_err_r <= 1'b1;
        end
        default: begin
          state_r     <= S_BOOT;
          pc_r        <= RESET_PC;
          dec_valid_r <= 1'b0;
          fetch_err_r <= 1'b0;
        end
      endcase
    end
  end

  // Decoder-facing outputs; ROM data is masked whenever nothing valid is presented.
  always_comb begin
    if (dec_valid_r) begin
      dec_instr = mem_instr;
      dec_imm   = mem_imm;
    end else begin
      dec_instr = NOP;
      dec_imm   = {WORD{1'b0}};
    end
  end

  assign dec_pc    = pc_r;
  assign dec_valid = dec_valid_r;

`ifdef IFETCH_BOUND_EN
  assign fetch_err = fetch_err_r;
`else
  assign fetch_err = fetch_err_r & 1'b0;
`endif

endmodule
